// File: rtl/lfsr_sample_fifo_if.sv
// Byte stream carrying serialized LFSR samples to the output pins or host.
// The producer drives byte/valid and the consumer drives ready.
interface lfsr_sample_fifo_if;
  logic [7:0] byte_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output byte_o, output valid_o, input ready_i);
  modport slave  (input byte_o, input valid_o, output ready_i);
endinterface

// File: rtl/lfsr_sample_fifo.sv
// Decimated sampler of the LFSR state with a DEPTH-word FIFO.
// Each word is serialized LSB byte first onto an 8-bit valid/ready stream.
module lfsr_sample_fifo #(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [7:0]           decim_i,
  input  logic [31:0]          lfsr_state_i,
  lfsr_sample_fifo_if.master   out_if,
  output logic [LW:0]          level_o,
  output logic [7:0]           overflow_cnt_o
);

  localparam logic [LW:0] FULL_LEVEL = (LW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [LW:0]   level;
  logic [1:0]    idx;
  logic [7:0]    cnt;
  logic [7:0]    ovf;

  logic        valid;
  logic        advance;
  logic        pop;
  logic        strobe;
  logic        wr;
  logic        drop;
  logic [31:0] head;
  logic [7:0]  byte_sel;

  // clear_i suppresses strobe, pop and byte advance in its cycle
  assign valid   = (level != '0);
  assign advance = valid && out_if.ready_i && !clear_i;
  assign pop     = advance && (idx == 2'd3);
  assign strobe  = enable_i && !clear_i && (cnt >= decim_i);
  assign wr      = strobe && ((level != FULL_LEVEL) || pop);
  assign drop    = strobe && !wr;
  assign head    = mem[rd_ptr];

  always_comb begin
    byte_sel = '0;
    unique case (idx)
      2'd0: byte_sel = head[7:0];
      2'd1: byte_sel = head[15:8];
      2'd2: byte_sel = head[23:16];
      2'd3: byte_sel = head[31:24];
    endcase
  end

  assign out_if.valid_o = valid;
  assign out_if.byte_o  = valid ? byte_sel : '0;
  assign level_o        = level;
  assign overflow_cnt_o = ovf;

  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr] <= lfsr_state_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      idx    <= '0;
      ovf    <= '0;
    end else if (clear_i) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      idx    <= '0;
      ovf    <= '0;
    end else begin
      if (!enable_i || strobe) cnt <= '0;
      else                     cnt <= cnt + 8'd1;
      if (wr)      wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)      level <= level + 1'b1;
      else if (!wr && pop) level <= level - 1'b1;
      // 2-bit index wraps 3 -> 0 on the popping byte
      if (advance) idx <= idx + 2'd1;
      if (drop && (ovf != 8'hFF)) ovf <= ovf + 8'd1;
    end
  end

endmodule

// File: tb/tb_lfsr_sample_fifo.sv
// Bench for lfsr_sample_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_lfsr_sample_fifo;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_i;
  logic        enable;
  logic        clear;
  logic [7:0]  decim;
  logic [31:0] lfsr;
  logic [2:0]  level;
  logic [7:0]  ovf_cnt;

  lfsr_sample_fifo_if sif ();

  lfsr_sample_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .enable_i       (enable),
    .clear_i        (clear),
    .decim_i        (decim),
    .lfsr_state_i   (lfsr),
    .out_if         (sif),
    .level_o        (level),
    .overflow_cnt_o (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total;
  int unsigned passed;

  // Reference model: the FIFO is a queue of words
  logic [31:0] mq [$];
  int unsigned m_idx;
  int unsigned m_cnt;
  int unsigned m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_idx = 0;
    m_cnt = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_edge();
    bit had_data;
    bit strobe;
    if (!reset_i || clear) begin
      model_reset();
      return;
    end
    had_data = (mq.size() != 0);
    strobe   = enable && (m_cnt >= int'(decim));
    if (!enable || strobe) m_cnt = 0;
    else                   m_cnt = m_cnt + 1;
    if (had_data && sif.ready_i) begin
      if (m_idx == 3) begin
        m_idx = 0;
        void'(mq.pop_front());
      end else begin
        m_idx = m_idx + 1;
      end
    end
    if (strobe) begin
      if (mq.size() < DEPTH) mq.push_back(lfsr);
      else if (m_ovf < 255)  m_ovf = m_ovf + 1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      passed = passed + 1;
  endtask

  task automatic compare_model();
    logic [31:0] exp_byte;
    exp_byte = '0;
    if (mq.size() != 0) exp_byte = (mq[0] >> (8 * m_idx)) & 32'hFF;
    chk("m_valid", {31'd0, sif.valid_o}, {31'd0, mq.size() != 0});
    chk("m_byte",  {24'd0, sif.byte_o}, exp_byte);
    chk("m_level", {29'd0, level}, mq.size());
    chk("m_ovf",   {24'd0, ovf_cnt}, m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic en, input logic [7:0] dc, input logic [31:0] w,
                       input logic rdy, input logic clr);
    enable      = en;
    decim       = dc;
    lfsr        = w;
    sif.ready_i = rdy;
    clear       = clr;
  endtask

  typedef struct {
    logic        en;
    logic [7:0]  dc;
    logic [31:0] w;
    logic        rdy;
    logic        v;
    logic [7:0]  b;
    logic [2:0]  lvl;
  } vec_t;

  vec_t vecs [10];

  logic [31:0] words [4];
  logic [7:0]  prev_byte;
  bit          hold;

  initial begin
    total = 0;
    passed = 0;
    model_reset();

    vecs[0] = '{1'b1, 8'd0, 32'hA1B2C3D4, 1'b1, 1'b1, 8'hD4, 3'd1};
    vecs[1] = '{1'b0, 8'd0, 32'h00000000, 1'b1, 1'b1, 8'hC3, 3'd1};
    vecs[2] = '{1'b0, 8'd0, 32'h00000000, 1'b1, 1'b1, 8'hB2, 3'd1};
    vecs[3] = '{1'b0, 8'd0, 32'h00000000, 1'b1, 1'b1, 8'hA1, 3'd1};
    vecs[4] = '{1'b0, 8'd0, 32'h00000000, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[5] = '{1'b0, 8'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[6] = '{1'b1, 8'd2, 32'h11223344, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[7] = '{1'b1, 8'd2, 32'h55667788, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[8] = '{1'b1, 8'd2, 32'h99AABBCC, 1'b0, 1'b1, 8'hCC, 3'd1};
    vecs[9] = '{1'b0, 8'd2, 32'h00000000, 1'b0, 1'b1, 8'hCC, 3'd1};

    // Reset held with random inputs toggling
    reset_i = 1'b0;
    drive(1'b0, 8'd0, 32'd0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 12; i++) begin
      drive(1'($urandom), 8'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom));
      cycle();
      chk("rst_valid", {31'd0, sif.valid_o}, 32'd0);
      chk("rst_byte", {24'd0, sif.byte_o}, 32'd0);
    end
    drive(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
    #2 reset_i = 1'b1;
    for (int unsigned i = 0; i < 3; i++) cycle();

    // Vector table: single-sample serialization and decimation by 3
    for (int unsigned i = 0; i < 10; i++) begin
      drive(vecs[i].en, vecs[i].dc, vecs[i].w, vecs[i].rdy, 1'b0);
      cycle();
      chk("vec_valid", {31'd0, sif.valid_o}, {31'd0, vecs[i].v});
      chk("vec_byte", {24'd0, sif.byte_o}, {24'd0, vecs[i].b});
      chk("vec_level", {29'd0, level}, {29'd0, vecs[i].lvl});
    end

    // Decimation by 5 with no drain, then saturating overflow
    drive(1'b0, 8'd0, 32'd0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 8'd4, 32'h0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 20; i++) begin
      lfsr = $urandom;
      cycle();
    end
    chk("dec_level4", {29'd0, level}, 32'd4);
    chk("dec_ovf0", {24'd0, ovf_cnt}, 32'd0);
    for (int unsigned i = 0; i < 5; i++) cycle();
    chk("dec_ovf1", {24'd0, ovf_cnt}, 32'd1);
    for (int unsigned i = 0; i < 1300; i++) cycle();
    chk("ovf_sat", {24'd0, ovf_cnt}, 32'd255);
    for (int unsigned i = 0; i < 10; i++) cycle();
    chk("ovf_hold", {24'd0, ovf_cnt}, 32'd255);

    // Full FIFO accepting a strobe in the same cycle as the pop
    drive(1'b0, 8'd0, 32'd0, 1'b0, 1'b1);
    cycle();
    for (int unsigned k = 0; k < 4; k++) begin
      drive(1'b1, 8'd0, 32'h01020304 + k * 32'h10101010, 1'b0, 1'b0);
      cycle();
    end
    chk("full_level", {29'd0, level}, 32'd4);
    drive(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) cycle();
    drive(1'b1, 8'd0, 32'hCAFEF00D, 1'b1, 1'b0);
    cycle();
    chk("fp_level", {29'd0, level}, 32'd4);
    chk("fp_ovf", {24'd0, ovf_cnt}, 32'd0);
    words[0] = 32'h11121314;
    words[1] = 32'h21222324;
    words[2] = 32'h31323334;
    words[3] = 32'hCAFEF00D;
    drive(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        chk("fp_order", {24'd0, sif.byte_o}, (words[k] >> (8 * b)) & 32'hFF);
        cycle();
      end
    end
    chk("fp_empty", {31'd0, sif.valid_o}, 32'd0);

    // Flush mid-word with a coincident strobe
    drive(1'b1, 8'd0, 32'h55AA1234, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    cycle();
    chk("fl_mid", {24'd0, sif.byte_o}, 32'hAA);
    drive(1'b1, 8'd0, 32'hDEADBEEF, 1'b1, 1'b1);
    cycle();
    chk("fl_valid", {31'd0, sif.valid_o}, 32'd0);
    chk("fl_level", {29'd0, level}, 32'd0);
    chk("fl_ovf", {24'd0, ovf_cnt}, 32'd0);
    drive(1'b1, 8'd0, 32'h0BADC0DE, 1'b0, 1'b0);
    cycle();
    chk("fl_restart", {24'd0, sif.byte_o}, 32'hDE);

    // Asynchronous reset between edges, mid-word
    drive(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    chk("ar_before", {24'd0, sif.byte_o}, 32'hC0);
    #2 reset_i = 1'b0;
    #1;
    chk("ar_valid", {31'd0, sif.valid_o}, 32'd0);
    chk("ar_byte", {24'd0, sif.byte_o}, 32'd0);
    chk("ar_level", {29'd0, level}, 32'd0);
    model_reset();
    #1 reset_i = 1'b1;
    drive(1'b0, 8'd0, 32'd0, 1'b0, 1'b0);
    cycle();

    // Randomized traffic with backpressure
    for (int unsigned i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3)), $urandom,
            1'($urandom), ($urandom_range(0, 39) == 0));
      hold      = sif.valid_o && !sif.ready_i && !clear;
      prev_byte = sif.byte_o;
      cycle();
      if (hold) chk("bp_hold", {24'd0, sif.byte_o}, {24'd0, prev_byte});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lfsr_sample_fifo.md
Name: lfsr_sample_fifo

Overview:
Downstream consumer of the free-running 32-bit LFSR state. It samples the LFSR word once every (decim_i+1) enabled cycles and buffers the samples in a DEPTH-word FIFO. Each buffered word is serialized least-significant byte first onto an 8-bit valid/ready stream that feeds the chip's output pins or a host interface. Samples that arrive while the FIFO is full are dropped and counted.

Parameters:
DEPTH, 4, FIFO depth in 32-bit words; must be a power of two and at least 2.
LW, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
reset_i  input  1  asynchronous, active-low reset.
enable_i  input  1  sampling enable.
clear_i  input  1  synchronous flush of FIFO, counters and byte index.
decim_i  input  8  decimation; sample period is decim_i+1 enabled cycles.
lfsr_state_i  input  32  LFSR state word, sampled as-is.
byte_o  output  8  current output byte.
valid_o  output  1  byte_o holds valid data.
ready_i  input  1  downstream accepts byte_o this cycle.
level_o  output  LW+1  number of words stored (0..DEPTH).
overflow_cnt_o  output  8  dropped-sample count; saturates at 255.

Behaviour:
- Reset (reset_i=0, async): FIFO empty, rd/wr pointers 0, byte index 0, decimation counter 0, overflow_cnt_o=0, level_o=0, valid_o=0, byte_o=0.
- Decimation counter (cnt, 8 bit):
  - enable_i=0: cnt forced to 0, no strobe.
  - enable_i=1 and cnt>=decim_i: strobe asserted, cnt<=0.
  - otherwise cnt<=cnt+1.
  - decim_i=0 gives a strobe on every enabled cycle.
  - If decim_i is lowered below cnt, the >= compare strobes on the next enabled cycle.
- Pop: occurs when valid_o & ready_i & byte index==3.
- Write on strobe: lfsr_state_i is written at the tail if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle. Otherwise the sample is dropped and overflow_cnt_o increments, holding at 255.
- Output side:
  - valid_o = (level!=0), registered-state derived.
  - byte_o = head_word[8*idx +: 8], idx in 0..3, LSB first; byte_o is 0 when empty.
  - valid_o & ready_i: idx<=idx+1. When idx==3, idx<=0 and the head word is popped.
  - valid_o & !ready_i: byte_o and valid_o hold stable.
- Latency: a sample written at edge N gives valid_o=1 after edge N, with its byte 0 on byte_o, if the FIFO was empty. No combinational path from lfsr_state_i to byte_o.
- Simultaneous write and pop: level unchanged; both pointers advance modulo DEPTH.
- level_o updates each edge: +1 on write only, -1 on pop only, unchanged otherwise.
- clear_i=1 overrides write, pop and strobe in the same cycle. Next state: level 0, pointers 0, idx 0, cnt 0, overflow_cnt_o 0, valid_o 0.
- Asserting reset_i mid-word discards all partial state immediately, without waiting for a clock edge.
- ready_i while valid_o=0 has no effect.

Test Plan:
- Reset: hold reset_i=0 with random inputs toggling -> valid_o=0, level_o=0, overflow_cnt_o=0, byte_o=0 throughout; release shows no spurious valid.
- Single sample: decim_i=0, enable_i high for 1 cycle with lfsr_state_i=0xA1B2C3D4, ready_i=1 -> byte_o D4,C3,B2,A1 on 4 consecutive cycles with valid_o=1, then valid_o=0, level_o returns to 0.
- Decimation and overflow: decim_i=4, enable_i=1, ready_i=0 -> strobe every 5 cycles; level_o reaches 4 after 4 strobes; overflow_cnt_o=1 after the 5th strobe; after 260 further strobes overflow_cnt_o=255 and holds.
- Full with simultaneous pop: FIFO full with idx=3, ready_i=1 on a strobe cycle -> new word accepted, level_o stays 4, overflow_cnt_o unchanged; the new word is read out last, in order.
- Backpressure: ready_i driven pseudo-randomly over 8 stored words -> byte_o constant whenever valid_o=1 & ready_i=0; the 32-byte output sequence equals the sampled words LSB first.
- Flush and reset mid-word: consume 2 bytes, then pulse clear_i with a strobe in the same cycle -> next cycle valid_o=0, level_o=0, sample dropped and not counted; next sample starts at byte 0. Repeat with reset_i pulsed between edges -> outputs go to 0 asynchronously.
